sc_sweep_counter: RTL

- Parametrised ping-pong sweep counter that drives horizontal formation movement: position walks MIN_POS→MAX_POS, dwells at the edge, walks back, dwells, repeats.
- Generalises the fixed 11-state 4-bit sweep FSM with:
  - configurable range, width and edge dwell;
  - a built-in programmable step prescaler;
  - a one-clock descend pulse with a saturating row counter and bottom flag.
- Sits between the game-speed control and the formation/sprite position logic.

---
 rtl/sc_sweep_counter_pkg.sv | 21 ++
 rtl/sc_sweep_counter_if.sv | 49 ++++
 rtl/sc_step_prescaler.sv | 44 ++++
 rtl/sc_sweep_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sc_sweep_counter_pkg.sv
// -----------------------------------------------------------------------------
// sc_sweep_counter_pkg
// Shared definitions for the formation sweep counter:
//   - sweep_state_t : four-state ping-pong sweep FSM encoding
//   - DIR_*         : direction codes presented on the dir output
// No ports (package).
// -----------------------------------------------------------------------------
package sc_sweep_counter_pkg;

  typedef enum logic [1:0] {
    ST_MOVE_R = 2'b00,
    ST_EDGE_R = 2'b01,
    ST_MOVE_L = 2'b10,
    ST_EDGE_L = 2'b11
  } sweep_state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_EDGE  = 2'b00;

endpackage : sc_sweep_counter_pkg

// File: rtl/sc_sweep_counter_if.sv
// -----------------------------------------------------------------------------
// sc_sweep_counter_if
// Control/status bundle between the game-speed controller (master) and the
// sweep counter (slave).
//   master drives : SC_SWEEP_CLEAR_InHigh, SC_SWEEP_enable_InHigh,
//                   SC_SWEEP_rateDiv_In
//   slave drives  : SC_SWEEP_dir_Out, SC_SWEEP_position_Out,
//                   SC_SWEEP_descend_OutPulse, SC_SWEEP_rows_Out,
//                   SC_SWEEP_bottom_Out
// Parameters must match the sc_sweep_counter instance it connects to.
// -----------------------------------------------------------------------------
interface sc_sweep_counter_if #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8,
  parameter int ROW_W = 3
) ();

  logic             SC_SWEEP_CLEAR_InHigh;
  logic             SC_SWEEP_enable_InHigh;
  logic [DIV_W-1:0] SC_SWEEP_rateDiv_In;
  logic [1:0]       SC_SWEEP_dir_Out;
  logic [WIDTH-1:0] SC_SWEEP_position_Out;
  logic             SC_SWEEP_descend_OutPulse;
  logic [ROW_W-1:0] SC_SWEEP_rows_Out;
  logic             SC_SWEEP_bottom_Out;

  modport master (
    output SC_SWEEP_CLEAR_InHigh,
    output SC_SWEEP_enable_InHigh,
    output SC_SWEEP_rateDiv_In,
    input  SC_SWEEP_dir_Out,
    input  SC_SWEEP_position_Out,
    input  SC_SWEEP_descend_OutPulse,
    input  SC_SWEEP_rows_Out,
    input  SC_SWEEP_bottom_Out
  );

  modport slave (
    input  SC_SWEEP_CLEAR_InHigh,
    input  SC_SWEEP_enable_InHigh,
    input  SC_SWEEP_rateDiv_In,
    output SC_SWEEP_dir_Out,
    output SC_SWEEP_position_Out,
    output SC_SWEEP_descend_OutPulse,
    output SC_SWEEP_rows_Out,
    output SC_SWEEP_bottom_Out
  );

endinterface : sc_sweep_counter_if

// File: rtl/sc_step_prescaler.sv
// -----------------------------------------------------------------------------
// sc_step_prescaler
// Programmable step prescaler: emits one tick every (rateDiv + 1) enabled
// clocks. Reusable for bullet and animation timing.
// Ports:
//   SC_PRESC_CLOCK_50       in  1      clock, rising edge
//   SC_PRESC_RESET_InHigh   in  1      synchronous reset, active-high
//   SC_PRESC_CLEAR_InHigh   in  1      synchronous restart, active-high
//   SC_PRESC_enable_InHigh  in  1      count enable; low holds the count
//   SC_PRESC_rateDiv_In     in  DIV_W  period minus 1, in clocks
//   SC_PRESC_tick_Out       out 1      step strobe (combinational)
// -----------------------------------------------------------------------------
module sc_step_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             SC_PRESC_CLOCK_50,
  input  logic             SC_PRESC_RESET_InHigh,
  input  logic             SC_PRESC_CLEAR_InHigh,
  input  logic             SC_PRESC_enable_InHigh,
  input  logic [DIV_W-1:0] SC_PRESC_rateDiv_In,
  output logic             SC_PRESC_tick_Out
);

  logic [DIV_W-1:0] presc_q;

  // '>=' rather than '==' so a rate lowered below the running count fires at
  // once instead of counting all the way round. presc never exceeds the
  // largest rateDiv seen, so it cannot overflow.
  assign SC_PRESC_tick_Out = SC_PRESC_enable_InHigh &&
                             (presc_q >= SC_PRESC_rateDiv_In);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SC_PRESC_CLOCK_50) begin
    if (SC_PRESC_RESET_InHigh || SC_PRESC_CLEAR_InHigh) begin
      presc_q <= '0;
    end else if (SC_PRESC_tick_Out) begin
      presc_q <= '0;
    end else if (SC_PRESC_enable_InHigh) begin
      presc_q <= presc_q + DIV_W'(1);
    end
  end

endmodule : sc_step_prescaler

// File: rtl/sc_sweep_counter.sv
// -----------------------------------------------------------------------------
// sc_sweep_counter
// Ping-pong sweep counter for horizontal formation movement. Position walks
// MIN_POS -> MAX_POS, dwells EDGE_HOLD ticks, walks back, dwells, repeats.
// Each edge entry emits a one-clock descend pulse and bumps a saturating row
// counter until MAX_ROWS, after which the sweep carries on without descending.
// Ports:
//   SC_SWEEP_CLOCK_50      in  1   clock, rising edge
//   SC_SWEEP_RESET_InHigh  in  1   synchronous reset, active-high
//   sweep_bus              sc_sweep_counter_if.slave
//     CLEAR_InHigh  in   restart sweep, rows/bottom kept
//     enable_InHigh in   step enable (low = pause)
//     rateDiv_In    in   step period minus 1
//     dir_Out       out  01 right, 10 left, 00 at edge
//     position_Out  out  current position
//     descend_OutPulse out one-clock pulse after edge entry
//     rows_Out      out  rows descended (saturating)
//     bottom_Out    out  rows == MAX_ROWS
// All outputs are registered.
// -----------------------------------------------------------------------------
module sc_sweep_counter
  import sc_sweep_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN_POS   = 0,
  parameter int MAX_POS   = 10,
  parameter int EDGE_HOLD = 1,
  parameter int DIV_W     = 8,
  parameter int ROW_W     = 3,
  parameter int MAX_ROWS  = 7
) (
  input  logic               SC_SWEEP_CLOCK_50,
  input  logic               SC_SWEEP_RESET_InHigh,
  sc_sweep_counter_if.slave  sweep_bus
);

  localparam int HOLD_W = (EDGE_HOLD > 1) ? $clog2(EDGE_HOLD) : 1;

  localparam logic [WIDTH-1:0]  MIN_P     = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0]  MAX_P     = WIDTH'(MAX_POS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EDGE_HOLD - 1);
  localparam logic [ROW_W-1:0]  MAX_R     = ROW_W'(MAX_ROWS);

  sweep_state_t      state_q;
  logic [1:0]        dir_q;
  logic [WIDTH-1:0]  pos_q;
  logic [HOLD_W-1:0] hold_q;
  logic              descend_q;
  logic [ROW_W-1:0]  rows_q;
  logic              bottom_q;

  logic tick;
  logic clear;
  logic edge_entry;

  assign clear = sweep_bus.SC_SWEEP_CLEAR_InHigh;

  sc_step_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .SC_PRESC_CLOCK_50      (SC_SWEEP_CLOCK_50),
    .SC_PRESC_RESET_InHigh  (SC_SWEEP_RESET_InHigh),
    .SC_PRESC_CLEAR_InHigh  (clear),
    .SC_PRESC_enable_InHigh (sweep_bus.SC_SWEEP_enable_InHigh),
    .SC_PRESC_rateDiv_In    (sweep_bus.SC_SWEEP_rateDiv_In),
    .SC_PRESC_tick_Out      (tick)
  );

  // The tick that moves the FSM from a MOVE state into its edge state; this
  // is where the descend pulse and row increment originate.
  assign edge_entry = tick &&
                      (((state_q == ST_MOVE_R) && (pos_q == MAX_P)) ||
                       ((state_q == ST_MOVE_L) && (pos_q == MIN_P)));

  always_ff @(posedge SC_SWEEP_CLOCK_50) begin
    if (SC_SWEEP_RESET_InHigh) begin
      state_q   <= ST_MOVE_R;
      dir_q     <= DIR_RIGHT;
      pos_q     <= MIN_P;
      hold_q    <= '0;
      descend_q <= 1'b0;
      rows_q    <= '0;
      bottom_q  <= 1'b0;
    end else if (clear) begin
      // Restart the sweep but keep the formation's descended depth.
      state_q   <= ST_MOVE_R;
      dir_q     <= DIR_RIGHT;
      pos_q     <= MIN_P;
      hold_q    <= '0;
      descend_q <= 1'b0;
    end else begin
      descend_q <= 1'b0;

      if (edge_entry && (rows_q < MAX_R)) begin
        descend_q <= 1'b1;
        rows_q    <= rows_q + ROW_W'(1);
        bottom_q  <= ((rows_q + ROW_W'(1)) == MAX_R);
      end

      if (tick) begin
        case (state_q)
          ST_MOVE_R: begin
            if (pos_q == MAX_P) begin
              state_q <= ST_EDGE_R;
              dir_q   <= DIR_EDGE;
              hold_q  <= '0;
            end else begin
              pos_q <= pos_q + WIDTH'(1);
            end
          end
          ST_EDGE_R: begin
            if (hold_q == HOLD_LAST) begin
              state_q <= ST_MOVE_L;
              dir_q   <= DIR_LEFT;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          ST_MOVE_L: begin
            if (pos_q == MIN_P) begin
              state_q <= ST_EDGE_L;
              dir_q   <= DIR_EDGE;
              hold_q  <= '0;
            end else begin
              pos_q <= pos_q - WIDTH'(1);
            end
          end
          ST_EDGE_L: begin
            if (hold_q == HOLD_LAST) begin
              state_q <= ST_MOVE_R;
              dir_q   <= DIR_RIGHT;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
          default: begin
            // Corrupted state: restart the sweep from the left limit.
            state_q <= ST_MOVE_R;
            dir_q   <= DIR_RIGHT;
            pos_q   <= MIN_P;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign sweep_bus.SC_SWEEP_dir_Out          = dir_q;
  assign sweep_bus.SC_SWEEP_position_Out     = pos_q;
  assign sweep_bus.SC_SWEEP_descend_OutPulse = descend_q;
  assign sweep_bus.SC_SWEEP_rows_Out         = rows_q;
  assign sweep_bus.SC_SWEEP_bottom_Out       = bottom_q;

endmodule : sc_sweep_counter
